// File: rtl/clip_sample_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// clip_sample_sequencer_pkg
//
// Purpose:
//   Definitions shared by the clip sample sequencer, its sample-rate divider
//   and the record/play controller that drives it.
//
// Contents:
//   ADDR_W_DEFAULT   default clip-memory address width
//   seqState_t       sequencer FSM state encoding (IDLE, RUN, DONE)
//   CLIP0_BASE       base address of clip 0 (lower half of clip memory)
//   CLIP1_BASE       base address of clip 1 (upper half of clip memory)
//   divCounterWidth  width of a counter that must hold 0..sampleDiv-1
// ---------------------------------------------------------------------------
package clip_sample_sequencer_pkg;

    localparam int ADDR_W_DEFAULT = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState_t;

    // The controller picks one of these as startAddress when a clip is
    // selected; the two clips split the memory in half.
    localparam logic [ADDR_W_DEFAULT-1:0] CLIP0_BASE = 17'h00000;
    localparam logic [ADDR_W_DEFAULT-1:0] CLIP1_BASE = 17'h10000;

    // A divide-by-1 would need a zero-width counter, so never go below 1 bit.
    function automatic int divCounterWidth(input int sampleDiv);
        return (sampleDiv > 1) ? $clog2(sampleDiv) : 1;
    endfunction

endpackage

// File: rtl/clip_sample_sequencer_if.sv
// ---------------------------------------------------------------------------
// clip_sample_sequencer_if
//
// Purpose:
//   Bundles the controller-facing signals of the clip sample sequencer.
//
// Signals:
//   enableTimer   controller -> sequencer  level, high = run the clip
//   startAddress  controller -> sequencer  base address of selected clip
//   sampleTick    sequencer -> datapath    one-cycle per-sample strobe
//   address       sequencer -> datapath    current clip-memory address
//   sampleCount   sequencer -> controller  samples completed in this run
//   secondMarker  sequencer -> controller  one-cycle end-of-clip pulse
//   busy          sequencer -> controller  high while a clip is running
//
// Modports:
//   master  controller side (drives enableTimer/startAddress)
//   slave   sequencer side
// ---------------------------------------------------------------------------
interface clip_sample_sequencer_if #(
    parameter int ADDR_W = clip_sample_sequencer_pkg::ADDR_W_DEFAULT
);

    logic              enableTimer;
    logic [ADDR_W-1:0] startAddress;
    logic              sampleTick;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W:0]   sampleCount;
    logic              secondMarker;
    logic              busy;

    modport master (
        output enableTimer,
        output startAddress,
        input  sampleTick,
        input  address,
        input  sampleCount,
        input  secondMarker,
        input  busy
    );

    modport slave (
        input  enableTimer,
        input  startAddress,
        output sampleTick,
        output address,
        output sampleCount,
        output secondMarker,
        output busy
    );

endinterface

// File: rtl/clip_sample_sequencer_sample_rate_divider.sv
// ---------------------------------------------------------------------------
// clip_sample_sequencer_sample_rate_divider
//
// Purpose:
//   Divides the system clock down to the audio sample rate. The counter runs
//   0..SAMPLE_DIV-1 while 'run' is high and wraps; 'tick' marks the last
//   count of each period.
//
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   clear    synchronous clear of the counter (held while not running)
//   run      advance the counter this cycle
//   tick     combinational: run && counter == SAMPLE_DIV-1
//
// Parameters:
//   SAMPLE_DIV  clock cycles per sample period (>= 2)
// ---------------------------------------------------------------------------
module clip_sample_sequencer_sample_rate_divider
    import clip_sample_sequencer_pkg::*;
#(
    parameter int SAMPLE_DIV = 3125
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int               DIV_W    = divCounterWidth(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] divReg;

    // Gating with 'run' means a dropped enable suppresses the strobe in the
    // very cycle it would have fired.
    assign tick = run && (divReg == DIV_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            divReg <= '0;
        end else if (clear) begin
            divReg <= '0;
        end else if (run) begin
            if (tick) begin
                divReg <= '0;
            end else begin
                divReg <= divReg + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/clip_sample_sequencer.sv
// ---------------------------------------------------------------------------
// clip_sample_sequencer
//
// Purpose:
//   Timing and address engine of the voice recorder datapath. While the
//   controller holds enableTimer high it issues one sampleTick per sample
//   period, walks the clip-memory address from startAddress, counts samples
//   and raises secondMarker for one cycle after the last sample of the clip.
//
// Ports:
//   clock    system clock, all state changes on its rising edge
//   reset_n  asynchronous active-low reset (clears everything, no marker)
//   bus      clip_sample_sequencer_if.slave
//              in : enableTimer, startAddress
//              out: sampleTick, address, sampleCount, secondMarker, busy
//
// Parameters:
//   SAMPLE_DIV        clock cycles per sample period (>= 2)
//   SAMPLES_PER_CLIP  samples per clip (1 .. 2**ADDR_W)
//   ADDR_W            clip-memory address width; must match the interface
//
// Operation:
//   IDLE -> RUN   on an edge with enableTimer=1; startAddress is latched.
//   RUN  -> IDLE  enableTimer=0 aborts; address/sampleCount hold.
//   RUN  -> DONE  the tick that completes the clip; secondMarker pulses.
//   DONE -> IDLE  once enableTimer drops; a held enable never restarts.
// ---------------------------------------------------------------------------
module clip_sample_sequencer
    import clip_sample_sequencer_pkg::*;
#(
    parameter int SAMPLE_DIV       = 3125,
    parameter int SAMPLES_PER_CLIP = 65536,
    parameter int ADDR_W           = ADDR_W_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    clip_sample_sequencer_if.slave  bus
);

    // Clip length at the width of the sample counter; a full-memory clip
    // (2**ADDR_W samples) needs the extra count bit.
    localparam logic [ADDR_W:0] CLIP_LEN = (ADDR_W + 1)'(SAMPLES_PER_CLIP);

    seqState_t         stateReg;
    logic [ADDR_W-1:0] addressReg;
    logic [ADDR_W:0]   countReg;
    logic              markerReg;
    logic              busyReg;

    logic              divRun;
    logic              divClear;
    logic              tick;
    logic [ADDR_W:0]   countNext;

    // The divider only advances while running with the enable still high;
    // outside RUN it is held at zero so every run starts a full period.
    assign divRun    = (stateReg == RUN) && bus.enableTimer;
    assign divClear  = (stateReg != RUN);
    assign countNext = countReg + (ADDR_W + 1)'(1);

    clip_sample_sequencer_sample_rate_divider #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_divider (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (divClear),
        .run     (divRun),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg   <= IDLE;
            addressReg <= '0;
            countReg   <= '0;
            markerReg  <= 1'b0;
            busyReg    <= 1'b0;
        end else begin
            // The marker is a single-cycle pulse; only the completing tick
            // below sets it.
            markerReg <= 1'b0;

            case (stateReg)
                IDLE: begin
                    if (bus.enableTimer) begin
                        addressReg <= bus.startAddress;
                        countReg   <= '0;
                        stateReg   <= RUN;
                        busyReg    <= 1'b1;
                    end
                end

                RUN: begin
                    // Abort takes priority over a tick in the same cycle;
                    // the divider already gates that tick off.
                    if (!bus.enableTimer) begin
                        stateReg <= IDLE;
                        busyReg  <= 1'b0;
                    end else if (tick) begin
                        // Address wraps silently at the top of memory.
                        addressReg <= addressReg + ADDR_W'(1);
                        countReg   <= countNext;
                        if (countNext == CLIP_LEN) begin
                            stateReg  <= DONE;
                            markerReg <= 1'b1;
                            busyReg   <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    // Require a low level before a new run can start, so a
                    // controller that keeps enable high gets one clip only.
                    if (!bus.enableTimer) begin
                        stateReg <= IDLE;
                    end
                end

                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sampleTick   = tick;
    assign bus.address      = addressReg;
    assign bus.sampleCount  = countReg;
    assign bus.secondMarker = markerReg;
    assign bus.busy         = busyReg;

endmodule
